// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter granting one of four requesters exclusive access to a
// shared register. Each transaction takes three cycles: grant, apply, acknowledge.
module reg_access_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [7:0]         op,
  input  logic [4*WIDTH-1:0] din,
  output logic [3:0]         gnt,
  output logic               done,
  output logic               busy,
  output logic [WIDTH-1:0]   q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] q_q, q_d;

  logic             win_found;
  logic [1:0]       win_idx;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_din;

  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] code,
                                                input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] ld);
    case (code)
      2'b00:   apply_op = ld;
      2'b01:   apply_op = '1;
      2'b10:   apply_op = '0;
      default: apply_op = cur;
    endcase
  endfunction

  // ptr_q holds the last winner; the search starts just after it and wraps
  // around so that the last winner has the lowest priority.
  always_comb begin
    logic [1:0] cand;
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // While a transaction is active, ptr_q is also the granted requester.
  assign sel_op  = op[{ptr_q, 1'b0} +: 2];
  assign sel_din = din[ptr_q * WIDTH +: WIDTH];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    done_d  = 1'b0;
    q_d     = q_q;
    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (win_found) begin
          ptr_d   = win_idx;
          gnt_d   = 4'b0001 << win_idx;
          state_d = APPLY;
        end
      end
      APPLY: begin
        if (req[ptr_q]) begin
          q_d     = apply_op(sel_op, q_q, sel_din);
          done_d  = 1'b1;
          state_d = ACK;
        end else begin
          gnt_d   = 4'b0000;
          state_d = IDLE;
        end
      end
      ACK: begin
        gnt_d   = 4'b0000;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 4'b0000;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      gnt_q   <= 4'b0000;
      done_q  <= 1'b0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      q_q     <= q_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);
  assign q    = q_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Bench for reg_access_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_reg_access_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [31:0] din;
  logic [3:0]  gnt;
  logic        done;
  logic        busy;
  logic [7:0]  q;

  int n_chk  = 0;
  int n_fail = 0;

  reg_access_arbiter #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .op  (op),
    .din (din),
    .gnt (gnt),
    .done(done),
    .busy(busy),
    .q   (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase 0 = no transaction, 1 = granted, 2 = applied.
  int       m_phase = 0;
  int       m_ptr   = 3;
  int       m_win   = 0;
  bit       m_done  = 0;
  bit [7:0] m_q     = 8'h00;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0; m_ptr = 3; m_win = 0; m_done = 0; m_q = 8'h00;
    end else begin
      m_done = 0;
      if (m_phase == 0) begin
        for (int k = 1; k <= 4; k++) begin
          if (m_phase == 0 && req[(m_ptr + k) % 4]) begin
            m_win   = (m_ptr + k) % 4;
            m_phase = 1;
          end
        end
        if (m_phase == 1) m_ptr = m_win;
      end else if (m_phase == 1) begin
        if (req[m_win]) begin
          case (op[2*m_win +: 2])
            2'b00: m_q = din[8*m_win +: 8];
            2'b01: m_q = 8'hFF;
            2'b10: m_q = 8'h00;
            default: m_q = m_q;
          endcase
          m_done  = 1;
          m_phase = 2;
        end else begin
          m_phase = 0;
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_gnt",  {28'd0, gnt}, (m_phase != 0) ? (32'd1 << m_win) : 32'd0);
    check("model_done", {31'd0, done}, {31'd0, m_done});
    check("model_busy", {31'd0, busy}, (m_phase != 0) ? 32'd1 : 32'd0);
    check("model_q",    {24'd0, q}, {24'd0, m_q});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from requester r; req drops during ACK.
  task automatic txn(input int r, input logic [1:0] code, input logic [7:0] data,
                     input logic [7:0] exp_q);
    op  = 8'hE4;
    din = 32'hDEADBEEF;
    op[2*r +: 2] = code;
    din[8*r +: 8] = data;
    req = 4'(1 << r);
    step();
    check("txn_gnt",  {28'd0, gnt}, 32'd1 << r);
    check("txn_busy", {31'd0, busy}, 32'd1);
    step();
    check("txn_done", {31'd0, done}, 32'd1);
    check("txn_q",    {24'd0, q}, {24'd0, exp_q});
    req = 4'b0000;
    step();
    check("txn_gnt_clr",  {28'd0, gnt}, 32'd0);
    check("txn_done_clr", {31'd0, done}, 32'd0);
  endtask

  int order[4];
  int nd;
  int idx;

  initial begin
    rst = 1'b1; req = 4'b0000; op = 8'h00; din = 32'h0;
    #1 rst = 1'b0;
    #2;
    check("rst_q",    {24'd0, q}, 32'd0);
    check("rst_gnt",  {28'd0, gnt}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("idle_gnt", {28'd0, gnt}, 32'd0);

    // Single load from requester 2
    txn(2, 2'b00, 8'hA5, 8'hA5);

    // Fresh reset, then all four request continuously
    rst = 1'b0; #1 rst = 1'b1;
    op = 8'h00; din = 32'h44332211; req = 4'b1111; nd = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (done) begin
        idx = 0;
        for (int b = 0; b < 4; b++) if (gnt[b]) idx = b;
        if (nd < 4) order[nd] = idx;
        nd++;
      end
    end
    req = 4'b0000;
    check("fair_count", nd, 4);
    for (int i = 0; i < 4; i++) check("fair_order", order[i], i);
    check("fair_q", {24'd0, q}, 32'h44);
    step();

    // Set, clear, hold
    txn(1, 2'b01, 8'h12, 8'hFF);
    txn(3, 2'b10, 8'h34, 8'h00);
    txn(0, 2'b11, 8'h56, 8'h00);

    // Abort in APPLY, then pointer continues from requester 1
    op = 8'h00; din = 32'h00007755; req = 4'b0010;
    step();
    check("abort_gnt", {28'd0, gnt}, 32'b0010);
    req = 4'b0000;
    step();
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_gnt_clr", {28'd0, gnt}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_q", {24'd0, q}, 32'h00);
    req = 4'b0011;
    step();
    check("after_abort_gnt", {28'd0, gnt}, 32'b0001);
    step();
    check("after_abort_q", {24'd0, q}, 32'h55);
    req = 4'b0000;
    step();

    // Asynchronous reset during APPLY
    txn(2, 2'b00, 8'h3C, 8'h3C);
    op = 8'h00; din = 32'h000000C3; req = 4'b0001;
    step();
    check("pre_arst_gnt", {28'd0, gnt}, 32'b0001);
    #2 rst = 1'b0;
    #1;
    check("arst_q",    {24'd0, q}, 32'd0);
    check("arst_gnt",  {28'd0, gnt}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    req = 4'b0000;
    #2 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("post_arst_done", {31'd0, done}, 32'd0);
    end
    check("post_arst_q", {24'd0, q}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
